// File: rtl/key_hold_repeat.sv
// key_hold_repeat: turns debounced key press/release flags into adjust steps
// with auto-repeat, acceleration and short/long press classification.
module key_hold_repeat #(
  parameter int LONG_CNT = 50_000_000,
  parameter int REP_CNT  = 10_000_000,
  parameter int ACCEL_N  = 5,
  parameter int CW       = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Key_P_flag,
  input  logic       Key_R_flag,
  output logic       Step,
  output logic       Long_P_flag,
  output logic       Short_R_flag,
  output logic       Long_R_flag,
  output logic       Holding,
  output logic [7:0] Rep_num
);
  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;
  localparam int HALF = (REP_CNT / 2 > 1) ? REP_CNT / 2 : 1;
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] SLOW_END = CW'(REP_CNT - 1);
  localparam logic [CW-1:0] FAST_END = CW'(HALF - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] rep_q, rep_d;
  logic step_q, step_d, lp_q, lp_d, sr_q, sr_d, lr_q, lr_d;
  logic [CW-1:0] rep_end;
  assign rep_end = (int'(rep_q) < ACCEL_N) ? SLOW_END : FAST_END;
  // A press always restarts the hold; a release in the same cycle is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rep_d   = rep_q;
    step_d  = 1'b0;
    lp_d    = 1'b0;
    sr_d    = 1'b0;
    lr_d    = 1'b0;
    if (Key_P_flag) begin
      state_d = PRESS;
      cnt_d   = '0;
      rep_d   = '0;
      step_d  = 1'b1;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (Key_R_flag) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = state_q == PRESS;
      lr_d    = state_q == REPEAT;
    end else if (state_q == PRESS && cnt_q == LONG_END) begin
      state_d = REPEAT;
      cnt_d   = '0;
      rep_d   = 8'd1;
      step_d  = 1'b1;
      lp_d    = 1'b1;
    end else if (state_q == REPEAT && cnt_q == rep_end) begin
      cnt_d  = '0;
      rep_d  = rep_q + {7'd0, rep_q != 8'hFF};
      step_d = 1'b1;
    end
  end
  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      step_q  <= 1'b0;
      lp_q    <= 1'b0;
      sr_q    <= 1'b0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      step_q  <= step_d;
      lp_q    <= lp_d;
      sr_q    <= sr_d;
      lr_q    <= lr_d;
    end
  end
  assign Step         = step_q;
  assign Long_P_flag  = lp_q;
  assign Short_R_flag = sr_q;
  assign Long_R_flag  = lr_q;
  assign Holding      = state_q == REPEAT;
  assign Rep_num      = rep_q;
endmodule

// File: doc/key_hold_repeat.md
Name: key_hold_repeat

Overview:
- Sits between each key_filter output pair and the clock/calendar adjust state machine.
- Turns debounced press/release flags into adjust "Step" pulses: one step on press, then timed auto-repeat while the key is held, with acceleration after several repeats.
- Also classifies each press as short or long, so holding +/- sweeps digits and a long press can be decoded separately.

Parameters:
- LONG_CNT, 50_000_000, hold time in Clk cycles (1 s at 50 MHz) from the press Step to the long-press threshold; must be >= 2.
- REP_CNT, 10_000_000, auto-repeat interval in Clk cycles (200 ms); must be >= 2.
- ACCEL_N, 5, number of repeat Steps issued before the interval drops to REP_CNT/2.
- CW, 30, width of the internal interval counter; must hold LONG_CNT.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous reset, active-high: asserted = 1. The name is kept to match the other blocks' port lists.
- Key_P_flag  in  1  one-cycle debounced press pulse from key_filter.
- Key_R_flag  in  1  one-cycle debounced release pulse from key_filter.
- Step  out  1  one-cycle adjust pulse, issued on press and on each auto-repeat.
- Long_P_flag  out  1  one-cycle pulse when the hold reaches LONG_CNT.
- Short_R_flag  out  1  one-cycle pulse on release before the long threshold.
- Long_R_flag  out  1  one-cycle pulse on release after the long threshold.
- Holding  out  1  level; 1 while in the REPEAT state.
- Rep_num  out  8  count of repeat Steps in the current hold; saturates at 255.

Behaviour:
- Reset (async, Reset_n=1): state=IDLE, counter=0, Rep_num=0, all outputs 0. Reset mid-hold discards the hold; no release pulse is issued afterwards.
- All outputs are registered. Every pulse output is high for exactly one Clk cycle.
- States: IDLE, PRESS, REPEAT.
- IDLE:
  - Key_P_flag=1 at edge t: go to PRESS, Step=1 at t+1, counter=0, Rep_num=0.
  - Key_R_flag alone is ignored.
  - Both flags in the same cycle: treat as a press; the release is ignored.
- PRESS:
  - Counter increments each cycle.
  - Key_R_flag: go to IDLE, Short_R_flag=1 the next cycle.
  - When the counter reaches LONG_CNT-1, so that Long_P_flag appears exactly LONG_CNT cycles after the press Step:
    - go to REPEAT;
    - Long_P_flag=1 and Step=1 in the same cycle;
    - Rep_num=1, counter=0.
  - Release in the same cycle as the threshold: release wins. Short_R_flag=1, no Long_P_flag, no Step.
- REPEAT:
  - Holding=1. Counter increments each cycle.
  - Interval is REP_CNT while Rep_num < ACCEL_N; after that it is max(REP_CNT/2, 1) (integer divide).
  - When the counter reaches interval-1: Step=1, Rep_num+1 (saturate at 255), counter=0.
  - Key_R_flag: go to IDLE, Long_R_flag=1 the next cycle. No Step on that edge, even if the interval expires in the same cycle.
- Key_P_flag while in PRESS or REPEAT (a release was lost):
  - restart as a fresh press: PRESS, Step=1, counter=0, Rep_num=0;
  - no release pulse is issued.
- Rep_num holds its value in IDLE until the next press clears it.
- The counter never wraps: it is always cleared at a threshold or on a state change.

Test Plan:
(bench parameters: LONG_CNT=20, REP_CNT=8, ACCEL_N=3)
- Reset, then P pulse at cycle 10, R pulse at cycle 15 -> Step at 11, Short_R_flag at 16; no Long_P_flag, Holding stays 0, Rep_num=0.
- P at 10, held until R at 70 -> Step at 11; Long_P_flag+Step at 31 (Rep_num=1); Steps at 39, 47 (Rep_num=3); then every 4 cycles: 51, 55, ..., 67 (Rep_num=8); Long_R_flag at 71, Holding 0 from 71.
- P at 10, R arriving on the threshold edge (Long_P_flag would be at 31) -> Short_R_flag at 31; no Long_P_flag, no second Step.
- P at 10, second P at 40 with no release -> Step at 41, Rep_num=0, state PRESS; next Long_P_flag at 61; no Short_R_flag or Long_R_flag emitted.
- P and R in the same cycle while IDLE -> Step next cycle, state PRESS; a later R gives Short_R_flag.
- Reset asserted at cycle 35 during REPEAT, R at 40 -> all outputs 0 from reset; no Long_R_flag; next P behaves as a fresh press.
